// File: rtl/choreo_step_seq_pkg.sv
// Shared types and constants for the choreography step sequencer.
package choreo_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } choreo_state_t;

  localparam int CHOREO_STEPS            = 8;
  localparam int CHOREO_DW               = 8;
  localparam int CHOREO_PRESCALE_DEFAULT = 1000;

endpackage

// File: rtl/choreo_step_seq_if.sv
// Pattern-write, play-control and pattern-output signals of the step sequencer.
interface choreo_step_seq_if #(
  parameter int STEPS  = 8,
  parameter int DATA_W = 8
);
  localparam int AW = $clog2(STEPS);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     len;
  logic [3:0]        tempo;
  logic              loop_en;
  logic              start;
  logic              stop;
  logic [DATA_W-1:0] pattern_out;
  logic [AW-1:0]     step_idx;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, len, tempo, loop_en, start, stop,
    input  pattern_out, step_idx, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, tempo, loop_en, start, stop,
    output pattern_out, step_idx, busy, done
  );
endinterface

// File: rtl/choreo_step_seq_tick_gen.sv
// Beat prescaler: one-cycle beat on the last of every PRESCALE enabled cycles.
module choreo_tick_gen
  import choreo_pkg::*;
#(
  parameter int PRESCALE = CHOREO_PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic beat
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // Beat is decoded from the count so the wrap edge is also the advance edge.
  assign beat = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/choreo_step_seq.sv
// Eight-step choreography sequencer: pattern store, tempo-driven playback, registered output.
module choreo_step_seq
  import choreo_pkg::*;
#(
  parameter int STEPS    = CHOREO_STEPS,
  parameter int DATA_W   = CHOREO_DW,
  parameter int PRESCALE = CHOREO_PRESCALE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  choreo_step_seq_if.slave bus
);
  localparam int AW = $clog2(STEPS);

  choreo_state_t     state;
  logic [DATA_W-1:0] mem [STEPS];
  logic [AW-1:0]     len_l;
  logic [3:0]        tempo_l;
  logic [3:0]        beat_cnt;
  logic [DATA_W-1:0] pattern_q;
  logic [AW-1:0]     step_q;
  logic [AW-1:0]     next_idx;
  logic              busy_q;
  logic              done_q;
  logic              go;
  logic              tick_en;
  logic              beat;

  assign go       = (state == ST_IDLE) && bus.start && !bus.stop;
  assign tick_en  = (state == ST_PLAY);
  assign next_idx = step_q + 1'b1;

  choreo_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (go),
    .en   (tick_en),
    .beat (beat)
  );

  // Reads below see pre-edge contents, giving read-before-write on collisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) mem[i] <= '0;
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pattern_q <= '0;
      step_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_l     <= '0;
      tempo_l   <= '0;
      beat_cnt  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            state     <= ST_PLAY;
            step_q    <= '0;
            pattern_q <= mem[0];
            busy_q    <= 1'b1;
            len_l     <= bus.len;
            tempo_l   <= bus.tempo;
            beat_cnt  <= '0;
          end
        end
        ST_PLAY: begin
          if (bus.stop) begin
            state     <= ST_IDLE;
            pattern_q <= '0;
            step_q    <= '0;
            busy_q    <= 1'b0;
          end else if (beat) begin
            if (beat_cnt != tempo_l) begin
              beat_cnt <= beat_cnt + 4'd1;
            end else begin
              beat_cnt <= '0;
              if (step_q < len_l) begin
                step_q    <= next_idx;
                pattern_q <= mem[next_idx];
              end else if (bus.loop_en) begin
                step_q    <= '0;
                pattern_q <= mem[0];
              end else begin
                state     <= ST_IDLE;
                pattern_q <= '0;
                step_q    <= '0;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pattern_out = pattern_q;
  assign bus.step_idx    = step_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_choreo_step_seq.sv
// Directed bench for choreo_step_seq with a 4-cycle beat.
module tb_choreo_step_seq;
  localparam int PRESCALE = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  choreo_step_seq_if #(.STEPS(8), .DATA_W(8)) bus ();

  choreo_step_seq #(.STEPS(8), .DATA_W(8), .PRESCALE(PRESCALE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick(1);
    bus.wr_en   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    n_checks++;
    if (bus.pattern_out !== 8'h00 || bus.step_idx !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pat=%h idx=%0d busy=%b done=%b want 00/0/0/0",
               bus.pattern_out, bus.step_idx, bus.busy, bus.done);
    end
    rst = 1'b0;
    tick(1);
    wr(3'd0, 8'h5A);
    bus.len = 3'd0; bus.tempo = 4'd0; bus.loop_en = 1'b0; bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    n_checks++;
    if (bus.pattern_out !== 8'h5A || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prerun: got pat=%h busy=%b want 5a/1", bus.pattern_out, bus.busy);
    end
    tick(1);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.pattern_out !== 8'h00 || bus.step_idx !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got pat=%h idx=%0d busy=%b done=%b want 00/0/0/0",
               bus.pattern_out, bus.step_idx, bus.busy, bus.done);
    end
    tick(1);
    rst = 1'b0;
    tick(1);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.pattern_out !== 8'h00 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_empty_play[%0d]: got pat=%h busy=%b done=%b want 00/1/0",
                 i, bus.pattern_out, bus.busy, bus.done);
      end
      tick(1);
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_empty_done: got done=%b busy=%b want 1/0", bus.done, bus.busy);
    end
    tick(1);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done_pulse: got done=%b want 0", bus.done);
    end
  endtask

  task automatic test_basic;
    logic [7:0] exp_p;
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(1 << i));
    bus.len = 3'd7; bus.tempo = 4'd0; bus.loop_en = 1'b0; bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      exp_p = 8'(1 << (i / 4));
      n_checks++;
      if (bus.step_idx !== 3'(i / 4) || bus.pattern_out !== exp_p || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_cyc%0d: got idx=%0d pat=%h busy=%b done=%b want %0d/%h/1/0",
                 i, bus.step_idx, bus.pattern_out, bus.busy, bus.done, i / 4, exp_p);
      end
      tick(1);
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pattern_out !== 8'h00 || bus.step_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_done: got done=%b busy=%b pat=%h idx=%0d want 1/0/00/0",
               bus.done, bus.busy, bus.pattern_out, bus.step_idx);
    end
    tick(1);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after: got done=%b busy=%b want 0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_tempo_loop;
    int s;
    bus.len = 3'd1; bus.tempo = 4'd2; bus.loop_en = 1'b1; bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    for (int i = 0; i < 48; i++) begin
      s = (i / 12) % 2;
      n_checks++;
      if (bus.step_idx !== 3'(s) || bus.pattern_out !== 8'(1 << s) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL loop_cyc%0d: got idx=%0d pat=%h busy=%b done=%b want %0d/%h/1/0",
                 i, bus.step_idx, bus.pattern_out, bus.busy, bus.done, s, 8'(1 << s));
      end
      tick(1);
    end
    tick(12);
    n_checks++;
    if (bus.step_idx !== 3'd1 || bus.pattern_out !== 8'h02) begin
      n_fail++;
      $display("FAIL loop_step1: got idx=%0d pat=%h want 1/02", bus.step_idx, bus.pattern_out);
    end
    bus.loop_en = 1'b0;
    tick(11);
    n_checks++;
    if (bus.step_idx !== 3'd1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_last_hold: got idx=%0d busy=%b done=%b want 1/1/0", bus.step_idx, bus.busy, bus.done);
    end
    tick(1);
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pattern_out !== 8'h00) begin
      n_fail++;
      $display("FAIL loop_exit_done: got done=%b busy=%b pat=%h want 1/0/00", bus.done, bus.busy, bus.pattern_out);
    end
    tick(1);
  endtask

  task automatic test_stop;
    bus.len = 3'd7; bus.tempo = 4'd0; bus.loop_en = 1'b0; bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(3);
    bus.stop = 1'b1;
    tick(1);
    n_checks++;
    if (bus.pattern_out !== 8'h00 || bus.step_idx !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_on_advance: got pat=%h idx=%0d busy=%b done=%b want 00/0/0/0",
               bus.pattern_out, bus.step_idx, bus.busy, bus.done);
    end
    bus.stop = 1'b0;
    tick(1);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_no_done: got done=%b busy=%b want 0/0", bus.done, bus.busy);
    end
    bus.start = 1'b1; bus.stop = 1'b1;
    tick(2);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.pattern_out !== 8'h00) begin
      n_fail++;
      $display("FAIL stop_over_start: got busy=%b pat=%h want 0/00", bus.busy, bus.pattern_out);
    end
    bus.start = 1'b0; bus.stop = 1'b0;
    tick(1);
  endtask

  task automatic test_start_held;
    bus.len = 3'd1; bus.tempo = 4'd0; bus.loop_en = 1'b0; bus.start = 1'b1;
    tick(1);
    tick(4);
    n_checks++;
    if (bus.step_idx !== 3'd1 || bus.pattern_out !== 8'h02 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL held_no_restart: got idx=%0d pat=%h busy=%b want 1/02/1", bus.step_idx, bus.pattern_out, bus.busy);
    end
    tick(4);
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_done: got done=%b busy=%b want 1/0", bus.done, bus.busy);
    end
    tick(1);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.step_idx !== 3'd0 || bus.pattern_out !== 8'h01) begin
      n_fail++;
      $display("FAIL held_restart: got busy=%b done=%b idx=%0d pat=%h want 1/0/0/01",
               bus.busy, bus.done, bus.step_idx, bus.pattern_out);
    end
    bus.start = 1'b0; bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
  endtask

  task automatic test_collision;
    bus.len = 3'd1; bus.tempo = 4'd0; bus.loop_en = 1'b1; bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(3);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 8'hAA;
    tick(1);
    bus.wr_en = 1'b0;
    n_checks++;
    if (bus.step_idx !== 3'd1 || bus.pattern_out !== 8'h02) begin
      n_fail++;
      $display("FAIL coll_old_value: got idx=%0d pat=%h want 1/02", bus.step_idx, bus.pattern_out);
    end
    tick(4);
    n_checks++;
    if (bus.step_idx !== 3'd0 || bus.pattern_out !== 8'h01) begin
      n_fail++;
      $display("FAIL coll_wrap: got idx=%0d pat=%h want 0/01", bus.step_idx, bus.pattern_out);
    end
    tick(4);
    n_checks++;
    if (bus.step_idx !== 3'd1 || bus.pattern_out !== 8'hAA) begin
      n_fail++;
      $display("FAIL coll_new_value: got idx=%0d pat=%h want 1/aa", bus.step_idx, bus.pattern_out);
    end
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
  endtask

  task automatic test_live_param;
    bus.len = 3'd1; bus.tempo = 4'd0; bus.loop_en = 1'b0; bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.len = 3'd7; bus.tempo = 4'd3;
    tick(4);
    n_checks++;
    if (bus.step_idx !== 3'd1 || bus.pattern_out !== 8'hAA || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL live_tempo: got idx=%0d pat=%h busy=%b want 1/aa/1", bus.step_idx, bus.pattern_out, bus.busy);
    end
    tick(4);
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.step_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL live_len: got done=%b busy=%b idx=%0d want 1/0/0", bus.done, bus.busy, bus.step_idx);
    end
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.len = '0; bus.tempo = '0; bus.loop_en = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0;
    test_reset();
    test_basic();
    test_tempo_loop();
    test_stop();
    test_start_held();
    test_collision();
    test_live_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/choreo_step_seq.md
# choreo_step_seq

Eight-step choreography sequencer inside `tt_um_BMSCE_T2`. It sits directly upstream of `uo_out`. The top level decodes `ui_in`/`uio_in` into pattern writes and play commands. This block stores the 8-step pattern, plays it back at a programmable tempo, and drives the registered 8-bit pattern that the top level routes to `uo_out`.

## Interface
Parameters:
- `STEPS`, 8: pattern depth; address width is log2(STEPS) = 3.
- `DATA_W`, 8: pattern width.
- `PRESCALE`, 1000: clk cycles per beat; must be ≥ 2.

Ports:
- `clk`  in  1  single system clock.
- `rst`  in  1  asynchronous, active-high reset. The top level drives it from inverted `rst_n`.
- `wr_en`  in  1  write strobe for pattern memory.
- `wr_addr`  in  3  step address to write.
- `wr_data`  in  8  pattern value to write.
- `len`  in  3  last step index (number of steps − 1); sampled on start.
- `tempo`  in  4  beats per step minus 1; sampled on start.
- `loop_en`  in  1  wrap to step 0 after the last step; read live.
- `start`  in  1  level; begins playback when idle.
- `stop`  in  1  level; aborts playback.
- `pattern_out`  out  8  registered current pattern.
- `step_idx`  out  3  current step index.
- `busy`  out  1  high while in PLAY.
- `done`  out  1  one-cycle pulse on normal completion.

## Operation
- States: IDLE, PLAY.
- Reset (async, any time, including mid-play):
  - state → IDLE.
  - `pattern_out`=0, `step_idx`=0, `busy`=0, `done`=0.
  - All 8 memory words = 0; prescaler, beat counter, latched `len_l`/`tempo_l` = 0.
- Writes: `wr_en` writes `mem[wr_addr]` at the clock edge in any state. `pattern_out` is not updated by a write; the new value appears only when that step is next entered.
- Write/load collision: a write to the address being loaded on the same edge loads the OLD content (read-before-write).
- IDLE + `start`=1 + `stop`=0:
  - → PLAY.
  - `step_idx`=0, `pattern_out`=`mem[0]`, `busy`=1.
  - Latch `len_l`, `tempo_l`; clear prescaler and beat counter.
- PLAY, per cycle:
  - Prescaler counts 0..PRESCALE−1 and wraps; each wrap is a beat.
  - On the beat where beat counter == `tempo_l`, clear the beat counter and advance.
- Advance with `step_idx` < `len_l`: `step_idx`+1; `pattern_out`=`mem[step_idx+1]`.
- Advance with `step_idx` == `len_l` and `loop_en`=1: `step_idx`=0; `pattern_out`=`mem[0]`.
- Advance with `step_idx` == `len_l` and `loop_en`=0:
  - → IDLE.
  - `pattern_out`=0, `step_idx`=0, `busy`=0, `done`=1 for exactly one cycle.
- `stop`=1 in PLAY: → IDLE next edge; `pattern_out`=0, `step_idx`=0, `busy`=0, no `done`.
- Priority: `stop` over a same-cycle advance or completion; `stop` over `start`.
- `start` in PLAY is ignored (no restart). `start` held high through a completion restarts on the edge after `done`.
- Arithmetic:
  - Beat counter is 4 bits; prescaler is ceil(log2(PRESCALE)) bits.
  - Step index wraps only via explicit compare against `len_l`, never by overflow.
  - `len`=0 gives a single-step pattern.

## Timing
- Start latency: `start` sampled at edge k → `busy`=1 and `pattern_out`=`mem[0]` after edge k.
- Every step lasts exactly (tempo_l+1)·PRESCALE cycles, including step 0.
- Full pass: (len_l+1)(tempo_l+1)·PRESCALE cycles.
- `done`, the `busy` fall and the `pattern_out` clear occur on the same edge.
- Stop latency: 1 cycle.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package `choreo_pkg` holds:
  - state encoding (IDLE=0, PLAY=1);
  - constants `CHOREO_STEPS`, `CHOREO_DW`, `CHOREO_PRESCALE_DEFAULT`.
- Sub-module `choreo_tick_gen` is the prescaler:
  - inputs: `clk`, `rst`, `clr`, `en`;
  - output: one-cycle `beat` pulse every PRESCALE enabled cycles.
- The step memory stays as a flop array inside `choreo_step_seq` (8×8, reset-clearable).

## Test plan
(PRESCALE=4 for simulation.)
- Reset/idle: assert `rst` mid-run → all outputs 0 immediately. After release, `start` with `len`=0 and an empty memory → `pattern_out`=0 for 4 cycles, then `done` pulse.
- Basic playback: write mem = 0x01,0x02,0x04…0x80; `len`=7, `tempo`=0, `loop_en`=0; pulse `start` → `pattern_out` steps every 4 cycles, `step_idx` 0..7, `done` at cycle 32, `busy` falls on the same edge.
- Tempo and loop: `tempo`=2, `len`=1, `loop_en`=1 → each step holds 12 cycles, sequence 0,1,0,1…, no `done`. Drop `loop_en` during step 1 → completes after step 1.
- Stop priority: assert `stop` on the exact cycle of an advance → IDLE next edge, `pattern_out`=0, no `done`. `start`+`stop` together in IDLE → remains IDLE.
- Write collision: during PLAY write 0xAA to the address being loaded on that edge → old value shown; 0xAA appears on the next visit to that step.
- Live param change: change `len`/`tempo` mid-play → no effect until the next `start`.
